// File: rtl/pc_sequencer.sv
// Program counter and IDLE/RUN/HALTED run control for the single-cycle CPU.
// Resolves decoder branch requests against ALU flags; also counts retired instructions and FIFO stalls.
package cpuPkg;
  localparam int PC_W = 16;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_JUMP = 4'd1,
    BR_C    = 4'd2,
    BR_NC   = 4'd3,
    BR_N    = 4'd4,
    BR_P    = 4'd5,
    BR_Z    = 4'd6,
    BR_NZ   = 4'd7,
    BR_O    = 4'd8,
    BR_NO   = 4'd9,
    BR_FIFO = 4'd10
  } Branch;
endpackage

module pc_sequencer
  import cpuPkg::*;
#(
  parameter int                  PC_WIDTH    = cpuPkg::PC_W,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  STALL_LIMIT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  Branch                      branch_type,
  input  logic signed [PC_WIDTH-1:0] pc_offset,
  input  logic                       halt,
  input  logic                       flag_c,
  input  logic                       flag_n,
  input  logic                       flag_z,
  input  logic                       flag_o,
  output logic [PC_WIDTH-1:0]        pc,
  output logic                       run,
  output logic                       halted,
  output logic [31:0]                retired,
  output logic [15:0]                stall_cnt,
  output logic                       stall_timeout
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_ONE    = {{(PC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [15:0]         LIMIT     = 16'(STALL_LIMIT);
  localparam logic [15:0]         STALL_MAX = 16'hFFFF;

  state_t              state;
  state_t              state_next;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] pc_target;
  logic [PC_WIDTH-1:0] next_pc;
  logic                start_accept;
  logic                in_run;
  logic                fifo_stall;
  logic [15:0]         stall_inc;

  // Unconditional jumps and unknown encodings are folded in here; BR_FIFO is handled by the caller.
  function automatic logic branch_taken(input Branch b, input logic c, input logic n,
                                        input logic z, input logic o);
    logic t;
    t = 1'b0;
    case (b)
      BR_JUMP: t = 1'b1;
      BR_C:    t = c;
      BR_NC:   t = ~c;
      BR_N:    t = n;
      BR_P:    t = ~n & ~z;
      BR_Z:    t = z;
      BR_NZ:   t = ~z;
      BR_O:    t = o;
      BR_NO:   t = ~o;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == STALL_MAX) ? STALL_MAX : v + 16'd1;
  endfunction

  assign in_run       = (state == S_RUN);
  assign start_accept = start && (state == S_IDLE || state == S_HALTED);
  // halt overrides any branch, so a halting cycle never counts as a FIFO stall
  assign fifo_stall   = in_run && !halt && (branch_type == BR_FIFO);
  assign stall_inc    = sat_inc16(stall_cnt);

  // Offset is two's-complement; adding its raw bits gives the modulo-2^PC_WIDTH result.
  assign pc_inc    = pc + PC_ONE;
  assign pc_target = pc + $unsigned(pc_offset);

  always_comb begin
    next_pc = pc_inc;
    if (branch_type == BR_FIFO) begin
      next_pc = pc;
    end else if (branch_taken(branch_type, flag_c, flag_n, flag_z, flag_o)) begin
      next_pc = pc_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start) state_next = S_RUN;
      S_RUN:    if (halt)  state_next = S_HALTED;
      S_HALTED: if (start) state_next = S_RUN;
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    run    = (state == S_RUN);
    halted = (state == S_HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      case (state)
        S_IDLE:   if (start) pc <= RESET_PC;
        S_RUN:    if (!halt) pc <= next_pc;
        S_HALTED: if (start) pc <= pc_inc;
        default:  pc <= RESET_PC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired <= 32'd0;
    end else if (in_run && !fifo_stall) begin
      retired <= retired + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt     <= 16'd0;
      stall_timeout <= 1'b0;
    end else if (start_accept) begin
      stall_cnt     <= 16'd0;
      stall_timeout <= 1'b0;
    end else if (in_run) begin
      stall_cnt <= fifo_stall ? stall_inc : 16'd0;
      if (fifo_stall && stall_inc == LIMIT) begin
        stall_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a table of RUN-mode instructions with chained
// expected PCs, followed by hand-written halt/resume, wrap and reset sequences.
module tb_pc_sequencer;
  import cpuPkg::*;

  localparam int PW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  Branch                branch_type;
  logic signed [PW-1:0] pc_offset;
  logic                 halt;
  logic                 flag_c, flag_n, flag_z, flag_o;
  logic [PW-1:0]        pc;
  logic                 run, halted;
  logic [31:0]          retired;
  logic [15:0]          stall_cnt;
  logic                 stall_timeout;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.PC_WIDTH(PW), .RESET_PC(16'd0), .STALL_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .branch_type(branch_type),
    .pc_offset(pc_offset), .halt(halt),
    .flag_c(flag_c), .flag_n(flag_n), .flag_z(flag_z), .flag_o(flag_o),
    .pc(pc), .run(run), .halted(halted), .retired(retired),
    .stall_cnt(stall_cnt), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]           br;
    logic signed [PW-1:0] off;
    logic                 hlt, c, n, z, o;
    logic [PW-1:0]        e_pc;
    logic [31:0]          e_ret;
    logic [15:0]          e_stall;
    logic                 e_to, e_run, e_halted;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] br, input int off, input logic hlt,
                              input logic c, input logic n, input logic z, input logic o,
                              input int e_pc, input int e_ret, input int e_stall,
                              input logic e_to, input logic e_run, input logic e_halted);
    vec_t v;
    v.br = br; v.off = PW'(off); v.hlt = hlt;
    v.c = c; v.n = n; v.z = z; v.o = o;
    v.e_pc = PW'(e_pc); v.e_ret = 32'(e_ret); v.e_stall = 16'(e_stall);
    v.e_to = e_to; v.e_run = e_run; v.e_halted = e_halted;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] br, input int off, input logic hlt);
    branch_type = Branch'(br);
    pc_offset   = PW'(off);
    halt        = hlt;
  endtask

  task automatic check_all(input string tag, input int e_pc, input int e_ret, input int e_stall,
                           input logic e_to, input logic e_run, input logic e_halted);
    check({tag, " pc"}, 32'(pc), 32'(e_pc));
    check({tag, " retired"}, retired, 32'(e_ret));
    check({tag, " stall_cnt"}, 32'(stall_cnt), 32'(e_stall));
    check({tag, " stall_timeout"}, 32'(stall_timeout), 32'(e_to));
    check({tag, " run"}, 32'(run), 32'(e_run));
    check({tag, " halted"}, 32'(halted), 32'(e_halted));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "time limit");
  end

  initial begin
    // Chained trace starting at pc=0 in RUN; args: br, off, halt, c,n,z,o, pc, ret, stall, to, run, halted
    vecs.push_back(mk(BR_NONE,   0, 0, 0,0,0,0,  1,  1, 0, 0, 1, 0));
    vecs.push_back(mk(BR_NONE,   0, 0, 0,0,0,0,  2,  2, 0, 0, 1, 0));
    vecs.push_back(mk(BR_NONE,   0, 0, 0,0,0,0,  3,  3, 0, 0, 1, 0));
    vecs.push_back(mk(BR_JUMP,   7, 0, 0,0,0,0, 10,  4, 0, 0, 1, 0));
    vecs.push_back(mk(BR_JUMP,  -4, 0, 0,0,0,0,  6,  5, 0, 0, 1, 0));
    vecs.push_back(mk(BR_Z,     14, 0, 0,0,1,0, 20,  6, 0, 0, 1, 0));
    vecs.push_back(mk(BR_Z,      5, 0, 0,0,0,0, 21,  7, 0, 0, 1, 0));
    vecs.push_back(mk(BR_JUMP,  -1, 0, 0,0,0,0, 20,  8, 0, 0, 1, 0));
    vecs.push_back(mk(BR_Z,      5, 0, 0,0,1,0, 25,  9, 0, 0, 1, 0));
    vecs.push_back(mk(BR_C,      3, 0, 1,0,0,0, 28, 10, 0, 0, 1, 0));
    vecs.push_back(mk(BR_C,      3, 0, 0,0,0,0, 29, 11, 0, 0, 1, 0));
    vecs.push_back(mk(BR_NC,    -2, 0, 0,0,0,0, 27, 12, 0, 0, 1, 0));
    vecs.push_back(mk(BR_NC,    -2, 0, 1,0,0,0, 28, 13, 0, 0, 1, 0));
    vecs.push_back(mk(BR_N,      2, 0, 0,1,0,0, 30, 14, 0, 0, 1, 0));
    vecs.push_back(mk(BR_N,      2, 0, 0,0,0,0, 31, 15, 0, 0, 1, 0));
    vecs.push_back(mk(BR_P,     -3, 0, 0,0,0,0, 28, 16, 0, 0, 1, 0));
    vecs.push_back(mk(BR_P,     -3, 0, 0,0,1,0, 29, 17, 0, 0, 1, 0));
    vecs.push_back(mk(BR_P,     -3, 0, 0,1,0,0, 30, 18, 0, 0, 1, 0));
    vecs.push_back(mk(BR_NZ,     4, 0, 0,0,0,0, 34, 19, 0, 0, 1, 0));
    vecs.push_back(mk(BR_NZ,     4, 0, 0,0,1,0, 35, 20, 0, 0, 1, 0));
    vecs.push_back(mk(BR_O,     -5, 0, 0,0,0,1, 30, 21, 0, 0, 1, 0));
    vecs.push_back(mk(BR_O,     -5, 0, 0,0,0,0, 31, 22, 0, 0, 1, 0));
    vecs.push_back(mk(BR_NO,     2, 0, 0,0,0,0, 33, 23, 0, 0, 1, 0));
    vecs.push_back(mk(BR_NO,     2, 0, 0,0,0,1, 34, 24, 0, 0, 1, 0));
    vecs.push_back(mk(4'd13,     9, 0, 1,1,1,1, 35, 25, 0, 0, 1, 0));
    vecs.push_back(mk(BR_JUMP,   0, 0, 0,0,0,0, 35, 26, 0, 0, 1, 0));
    vecs.push_back(mk(BR_JUMP, -28, 0, 0,0,0,0,  7, 27, 0, 0, 1, 0));
    vecs.push_back(mk(BR_FIFO,   3, 0, 0,0,0,0,  7, 27, 1, 0, 1, 0));
    vecs.push_back(mk(BR_FIFO,   3, 0, 0,0,0,0,  7, 27, 2, 0, 1, 0));
    vecs.push_back(mk(BR_FIFO,   3, 0, 0,0,0,0,  7, 27, 3, 0, 1, 0));
    vecs.push_back(mk(BR_FIFO,   3, 0, 0,0,0,0,  7, 27, 4, 1, 1, 0));
    vecs.push_back(mk(BR_NONE,   0, 0, 0,0,0,0,  8, 28, 0, 1, 1, 0));
    vecs.push_back(mk(BR_JUMP,   4, 0, 0,0,0,0, 12, 29, 0, 1, 1, 0));
    vecs.push_back(mk(BR_NONE,   0, 1, 0,0,0,0, 12, 30, 0, 1, 0, 1));

    rst = 1'b1; start = 1'b0;
    drive(BR_NONE, 0, 1'b0);
    flag_c = 0; flag_n = 0; flag_z = 0; flag_o = 0;
    step(); step();
    check_all("reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);

    rst = 1'b0;
    step();
    check_all("idle hold", 0, 0, 0, 1'b0, 1'b0, 1'b0);

    start = 1'b1;
    step();
    start = 1'b0;
    check_all("start", 0, 0, 0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].br, int'(vecs[i].off), vecs[i].hlt);
      flag_c = vecs[i].c; flag_n = vecs[i].n; flag_z = vecs[i].z; flag_o = vecs[i].o;
      step();
      check_all($sformatf("vec%0d", i), int'(vecs[i].e_pc), int'(vecs[i].e_ret),
                int'(vecs[i].e_stall), vecs[i].e_to, vecs[i].e_run, vecs[i].e_halted);
    end

    // HALTED ignores the decoder until start
    drive(BR_JUMP, 100, 1'b0);
    step();
    check_all("halted hold", 12, 30, 0, 1'b1, 1'b0, 1'b1);

    start = 1'b1;
    drive(BR_NONE, 0, 1'b0);
    step();
    start = 1'b0;
    check_all("resume", 13, 30, 0, 1'b0, 1'b1, 1'b0);

    // Wrap in both directions
    drive(BR_JUMP, -13, 1'b0);
    step();
    check_all("to zero", 0, 31, 0, 1'b0, 1'b1, 1'b0);
    drive(BR_JUMP, -1, 1'b0);
    step();
    check_all("wrap down", 65535, 32, 0, 1'b0, 1'b1, 1'b0);
    drive(BR_NONE, 0, 1'b0);
    step();
    check_all("wrap up", 0, 33, 0, 1'b0, 1'b1, 1'b0);

    // start held across HALT: one HALTED cycle, then resume; start in RUN is inert
    start = 1'b1;
    drive(BR_NONE, 0, 1'b1);
    step();
    check_all("held halt", 0, 34, 0, 1'b0, 1'b0, 1'b1);
    drive(BR_NONE, 0, 1'b0);
    step();
    check_all("held resume", 1, 34, 0, 1'b0, 1'b1, 1'b0);
    step();
    check_all("start in run", 2, 35, 0, 1'b0, 1'b1, 1'b0);
    start = 1'b0;

    // Reset mid-RUN at pc=30, with start also high
    drive(BR_JUMP, 28, 1'b0);
    step();
    check_all("pre reset", 30, 36, 0, 1'b0, 1'b1, 1'b0);
    rst = 1'b1; start = 1'b1;
    drive(BR_NONE, 0, 1'b0);
    step();
    check_all("mid-run reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; start = 1'b0;
    drive(BR_JUMP, 5, 1'b0);
    step();
    check_all("idle after reset", 0, 0, 0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and run-control stage that sits directly upstream of the instruction decoder in the single-cycle CPU. It holds the PC that addresses instruction memory and resolves the decoder's `branch_type`, `pc_offset` and `halt` against the ALU flags to choose the next PC each cycle. It also runs the IDLE/RUN/HALTED control state machine. It provides a retired-instruction counter and a FIFO-stall watchdog.

## Interface
Parameters:
- `PC_WIDTH`, default from `cpuPkg` — width of PC and `pc_offset`.
- `RESET_PC`, default 0 — PC loaded on reset and on start from IDLE.
- `STALL_LIMIT`, default 255 — consecutive FIFO-stall cycles before the watchdog fires; range 1..65535.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — level; IDLE→RUN, or HALTED→RUN (resume).
- `branch_type`  in  `Branch`  — from the decoder: BR_NONE, BR_JUMP, BR_C, BR_NC, BR_N, BR_P, BR_Z, BR_NZ, BR_O, BR_NO, BR_FIFO.
- `pc_offset`  in  PC_WIDTH  — signed offset from the decoder, already sign-extended.
- `halt`  in  1  — from the decoder.
- `flag_c`, `flag_n`, `flag_z`, `flag_o`  in  1 each  — registered ALU flags.
- `pc`  out  PC_WIDTH  — instruction-memory address (registered).
- `run`  out  1  — high only in RUN. The top level ANDs this into `regfile_wren`, `ram_wren` and the FIFO strobes.
- `halted`  out  1  — high in HALTED.
- `retired`  out  32  — retired-instruction count.
- `stall_cnt`  out  16  — current consecutive BR_FIFO cycle count.
- `stall_timeout`  out  1  — sticky watchdog flag.

## Operation
State machine, with `state` one of IDLE, RUN, HALTED:
- **IDLE:**
  - With `start`: go to RUN and set `pc`←RESET_PC.
  - Otherwise: hold.
- **RUN:**
  - `halt`=1: go to HALTED; `pc` is held at the HALT instruction.
  - Otherwise: `pc`←next_pc.
- **HALTED:**
  - With `start`: go to RUN and set `pc`←`pc`+1 (resume after HALT).
  - Otherwise: hold.
- Decoder inputs are ignored outside RUN.

next_pc in RUN:
- BR_NONE: `pc`+1.
- BR_JUMP: `pc`+`pc_offset`.
- Conditional branches use `pc`+`pc_offset` if taken, else `pc`+1. Taken conditions:
  - BR_C: C=1
  - BR_NC: C=0
  - BR_N: N=1
  - BR_P: N=0 and Z=0
  - BR_Z: Z=1
  - BR_NZ: Z=0
  - BR_O: O=1
  - BR_NO: O=0
- BR_FIFO: `pc` unchanged; the same instruction re-executes next cycle.
- Any other encoding: treated as BR_NONE.

Arithmetic:
- All PC sums are modulo 2^PC_WIDTH.
- `pc_offset` is two's-complement. Offset 0 yields a self-loop.
- Wrap-around is silent.

Retired counter:
- +1 per RUN cycle where `branch_type`≠BR_FIFO, including the HALT cycle.
- Wraps modulo 2^32.
- Not cleared by `start`.

Stall watchdog:
- In RUN with BR_FIFO: `stall_cnt` increments, saturating at 65535.
- In any other RUN cycle: `stall_cnt`←0.
- Outside RUN: `stall_cnt` is held.
- When `stall_cnt` becomes equal to STALL_LIMIT, `stall_timeout`←1 (sticky).
- The stall is not broken; software and the host observe it.
- `start` accepted from IDLE or HALTED clears `stall_timeout` and `stall_cnt`.

Reset:
- `state`=IDLE, `pc`=RESET_PC, `retired`=0, `stall_cnt`=0, `stall_timeout`=0.
- Outputs after reset: `run`=0, `halted`=0.
- Reset mid-RUN aborts immediately on that edge, with no further PC update. Reset wins over `start`.

## Timing
- `pc` is registered. The instruction it addresses is decoded combinationally in the same cycle, and next_pc is taken at the following edge, so one instruction completes per cycle.
- `run`, `halted`, `stall_timeout` and `stall_cnt` are registered and decode from state the cycle after a transition.
- `start` in RUN has no effect. `start` held high across a HALT causes a 1-cycle HALTED visit, then resume.
- `halt` and a branch cannot occur together: the decoder makes them mutually exclusive. If both are seen, `halt` wins.
- The first instruction fetch is at RESET_PC in the cycle after `start` is sampled.

## Test plan
- Reset, then `start` pulse with BR_NONE streamed → `pc` goes 0,1,2,3 on successive cycles; `run`=1 from the cycle after `start`; `retired`=3 after 3 RUN cycles.
- At `pc`=10, BR_JUMP with `pc_offset`=−4 → `pc`=6. At `pc`=0, BR_JUMP with offset −1 → `pc`=2^PC_WIDTH−1 (wrap).
- All eight conditional types with flags set both ways, e.g. BR_Z with Z=1, offset 5 at `pc`=20 → 25; with Z=0 → 21. Cover BR_P with N=0,Z=1 → not taken.
- BR_FIFO held for STALL_LIMIT=4 cycles at `pc`=7 → `pc` stays 7, `stall_cnt` goes 1..4, `stall_timeout`=1 when `stall_cnt` reaches 4; `retired` unchanged. Then BR_NONE → `pc`=8, `stall_cnt`=0, `stall_timeout` stays 1.
- `halt` at `pc`=12 → HALTED, `pc`=12, `run`=0, `retired` incremented by 1. Then `start` → RUN, `pc`=13, `stall_timeout` cleared.
- `rst` asserted mid-RUN at `pc`=30 with `start` also high → next cycle IDLE, `pc`=RESET_PC, all counters 0, `run`=0.
